// File: rtl/mostrador_multiplexado_pkg.sv
// rtl/mostrador_multiplexado_pkg.sv - shared types and constants for the multiplexed display
package pacote_mostrador;

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } estado_t;

  localparam logic [1:0] PERFIL_OFF  = 2'b00;
  localparam logic [1:0] PERFIL_A    = 2'b01;
  localparam logic [1:0] PERFIL_B    = 2'b10;
  localparam logic [1:0] PERFIL_ERRO = 2'b11;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_APAGADO = 7'b1111111;
  localparam logic [6:0] SEG_E       = 7'b0000110;
  localparam logic [6:0] SEG_TRACO   = 7'b0111111;

endpackage

// File: rtl/mostrador_multiplexado_decodificador.sv
// rtl/mostrador_multiplexado_decodificador.sv - BCD to active-low 7-segment, dash above 9
module decodificador_7seg
  import pacote_mostrador::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_TRACO;
    case (i_bcd)
      4'd0: o_seg = 7'b1000000;
      4'd1: o_seg = 7'b1111001;
      4'd2: o_seg = 7'b0100100;
      4'd3: o_seg = 7'b0110000;
      4'd4: o_seg = 7'b0011001;
      4'd5: o_seg = 7'b0010010;
      4'd6: o_seg = 7'b0000010;
      4'd7: o_seg = 7'b1111000;
      4'd8: o_seg = 7'b0000000;
      4'd9: o_seg = 7'b0010000;
      default: o_seg = SEG_TRACO;
    endcase
  end

endmodule

// File: rtl/mostrador_multiplexado.sv
// rtl/mostrador_multiplexado.sv - profile filter and 4-digit scan with inter-digit blanking
module mostrador_multiplexado
  import pacote_mostrador::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int HOLD_CYCLES  = 1000
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_bits_mostrador,
  input  logic        i_bits_mostrador1,
  input  logic [15:0] i_dados_a,
  input  logic [15:0] i_dados_b,
  output logic [6:0]  o_segmentos,
  output logic [3:0]  o_anodos,
  output logic [1:0]  o_perfil,
  output logic        o_troca_perfil
);

  localparam int SW = $clog2((REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES) + 1;
  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam logic [SW-1:0] FIM_BLANK = SW'(BLANK_CYCLES - 1);
  localparam logic [SW-1:0] FIM_ON    = SW'(REFRESH_DIV - 1);
  localparam logic [HW-1:0] FIM_HOLD  = HW'(HOLD_CYCLES - 1);

  logic [1:0]    r_sinc1, r_sinc2, r_cand, r_perfil;
  logic [HW-1:0] r_cnt_filtro;
  logic          r_troca;

  estado_t       r_estado, w_estado_prox;
  logic [SW-1:0] r_cnt_scan, w_cnt_scan_prox;
  logic [1:0]    r_idx, w_idx_prox;
  logic          w_captura, w_fim_slot;

  logic [15:0]   w_palavra;
  logic [3:0]    w_nibble;
  logic [6:0]    w_seg_dig;
  logic [6:0]    r_segmentos;
  logic [3:0]    r_anodos;

  // A candidate must stay stable for HOLD_CYCLES before it replaces the accepted profile
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sinc1      <= PERFIL_OFF;
      r_sinc2      <= PERFIL_OFF;
      r_cand       <= PERFIL_OFF;
      r_perfil     <= PERFIL_OFF;
      r_cnt_filtro <= '0;
      r_troca      <= 1'b0;
    end else begin
      r_sinc1 <= {i_bits_mostrador1, i_bits_mostrador};
      r_sinc2 <= r_sinc1;
      r_troca <= 1'b0;
      if (r_sinc2 != r_cand) begin
        r_cand       <= r_sinc2;
        r_cnt_filtro <= '0;
      end else if (r_cand != r_perfil) begin
        if (r_cnt_filtro == FIM_HOLD) begin
          r_perfil     <= r_cand;
          r_troca      <= 1'b1;
          r_cnt_filtro <= '0;
        end else begin
          r_cnt_filtro <= r_cnt_filtro + 1'b1;
        end
      end else begin
        r_cnt_filtro <= '0;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_estado   <= BLANK;
      r_cnt_scan <= '0;
      r_idx      <= 2'd0;
    end else begin
      r_estado   <= w_estado_prox;
      r_cnt_scan <= w_cnt_scan_prox;
      r_idx      <= w_idx_prox;
    end
  end

  always_comb begin
    w_estado_prox   = r_estado;
    w_cnt_scan_prox = r_cnt_scan + 1'b1;
    w_idx_prox      = r_idx;
    w_captura       = 1'b0;
    w_fim_slot      = 1'b0;
    case (r_estado)
      BLANK: begin
        if (r_cnt_scan == FIM_BLANK) begin
          w_estado_prox   = ON;
          w_cnt_scan_prox = '0;
          w_captura       = 1'b1;
        end
      end
      ON: begin
        if (r_cnt_scan == FIM_ON) begin
          w_estado_prox   = BLANK;
          w_cnt_scan_prox = '0;
          w_idx_prox      = r_idx + 2'd1;
          w_fim_slot      = 1'b1;
        end
      end
      default: begin
        w_estado_prox   = BLANK;
        w_cnt_scan_prox = '0;
      end
    endcase
  end

  assign w_palavra = (r_perfil == PERFIL_B) ? i_dados_b : i_dados_a;
  assign w_nibble  = w_palavra[{r_idx, 2'b00} +: 4];

  decodificador_7seg u_decodificador (
    .i_bcd (w_nibble),
    .o_seg (w_seg_dig)
  );

  // The slot's pattern is frozen at slot start; r_perfil here is the pre-update value
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_segmentos <= SEG_APAGADO;
      r_anodos    <= 4'b1111;
    end else if (w_captura) begin
      case (r_perfil)
        PERFIL_OFF: begin
          r_segmentos <= SEG_APAGADO;
          r_anodos    <= 4'b1111;
        end
        PERFIL_ERRO: begin
          r_segmentos <= SEG_E;
          r_anodos    <= ~(4'b0001 << r_idx);
        end
        default: begin
          r_segmentos <= w_seg_dig;
          r_anodos    <= ~(4'b0001 << r_idx);
        end
      endcase
    end else if (w_fim_slot) begin
      r_segmentos <= SEG_APAGADO;
      r_anodos    <= 4'b1111;
    end
  end

  assign o_segmentos    = r_segmentos;
  assign o_anodos       = r_anodos;
  assign o_perfil       = r_perfil;
  assign o_troca_perfil = r_troca;

endmodule
